// File: rtl/pe_traffic_gen.sv
// pe_traffic_gen: NoC PE that injects single-flit packets round-robin to the other PEs and checks the flits it receives.
// Ports:
//   sclk, rst                       clock, synchronous active-high reset
//   i_enable                        allows a new packet to start
//   i_data, i_data_valid            flit arriving from the NoC
//   o_data_ready                    sink ready, high whenever out of reset
//   o_data, o_data_valid            injected flit toward the NoC
//   i_data_ready                    NoC accepts the injected flit
//   o_tx_count, o_rx_count          packets sent and received
//   o_err_count                     receive check failures, saturating
//   o_done                          PKT_LIMIT packets have been injected
module pe_traffic_gen #(
    parameter int ADDRESS    = 0,
    parameter int NUM_PE     = 4,
    parameter int DATA_W     = 32,
    parameter int PKT_LIMIT  = 16,
    parameter int INJ_PERIOD = 8
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              i_enable,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_data_valid,
    output logic              o_data_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_data_valid,
    input  logic              i_data_ready,
    output logic [31:0]       o_tx_count,
    output logic [31:0]       o_rx_count,
    output logic [15:0]       o_err_count,
    output logic              o_done
);
    localparam int ADDR_W = (NUM_PE > 2) ? $clog2(NUM_PE) : 1;
    localparam logic [ADDR_W-1:0] ME = ADDR_W'(ADDRESS);
    localparam logic [ADDR_W-1:0] INIT = ADDR_W'((ADDRESS + 1) % NUM_PE);
    localparam logic [31:0] PERIOD = 32'(INJ_PERIOD);
    localparam logic [31:0] LIMIT = 32'(PKT_LIMIT);

    typedef enum logic [1:0] {GAP, SEND, DONE} state_t;

    state_t state_q, state_d;
    logic [31:0] gap_q, gap_d, tx_q, tx_d, rx_q, rx_d;
    logic [15:0] err_q, err_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] data_q, data_d, flit;
    logic ready_q;
    logic [15:0] seq_q [NUM_PE];
    logic [15:0] seq_d [NUM_PE];
    logic [15:0] exp_q [NUM_PE];
    logic [15:0] exp_d [NUM_PE];

    logic [ADDR_W-1:0] dst, src;
    logic [15:0] sq;
    logic acc, src_ok, bad, unused_bits;

    function automatic logic [ADDR_W-1:0] nxt(input logic [ADDR_W-1:0] p);
        return (32'(p) == 32'(NUM_PE - 1)) ? '0 : p + ADDR_W'(1);
    endfunction

    // Round-robin step that never lands on our own address.
    function automatic logic [ADDR_W-1:0] adv(input logic [ADDR_W-1:0] p);
        return (nxt(p) == ME) ? nxt(nxt(p)) : nxt(p);
    endfunction

    assign dst = i_data[ADDR_W-1:0];
    assign src = i_data[2*ADDR_W-1:ADDR_W];
    assign sq = i_data[DATA_W-1 -: 16];
    assign unused_bits = ^i_data;
    assign acc = i_data_valid & ready_q;
    assign src_ok = ({1'b0, src} < (ADDR_W+1)'(NUM_PE)) && (src != ME);
    assign bad = (dst != ME) || !src_ok || (sq != exp_q[src]);

    always_comb begin
        flit = '0;
        flit[ADDR_W-1:0] = ptr_q;
        flit[2*ADDR_W-1:ADDR_W] = ME;
        flit[DATA_W-1 -: 16] = seq_q[ptr_q];
    end

    always_comb begin
        state_d = state_q;
        gap_d = gap_q;
        tx_d = tx_q;
        rx_d = rx_q;
        err_d = err_q;
        ptr_d = ptr_q;
        data_d = data_q;
        seq_d = seq_q;
        exp_d = exp_q;
        case (state_q)
            GAP: begin
                // The gap only counts enabled cycles, so latency restarts from enable.
                gap_d = !i_enable ? '0 : (gap_q == PERIOD ? gap_q : gap_q + 32'd1);
                if (PKT_LIMIT == 0) state_d = DONE;
                else if (i_enable && gap_q == PERIOD && tx_q < LIMIT) begin
                    state_d = SEND;
                    data_d = flit;
                end
            end
            SEND: if (i_data_ready) begin
                tx_d = tx_q + 32'd1;
                seq_d[ptr_q] = seq_q[ptr_q] + 16'd1;
                ptr_d = adv(ptr_q);
                gap_d = '0;
                state_d = (tx_q + 32'd1 == LIMIT) ? DONE : GAP;
            end
            default: ;
        endcase
        if (acc) begin
            rx_d = rx_q + 32'd1;
            if (bad && err_q != 16'hFFFF) err_d = err_q + 16'd1;
            // Match or mismatch, the next expected value follows the received one.
            if (src_ok) exp_d[src] = sq + 16'd1;
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q <= GAP;
            gap_q <= '0;
            tx_q <= '0;
            rx_q <= '0;
            err_q <= '0;
            ptr_q <= INIT;
            data_q <= '0;
            ready_q <= 1'b0;
            seq_q <= '{default: '0};
            exp_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            gap_q <= gap_d;
            tx_q <= tx_d;
            rx_q <= rx_d;
            err_q <= err_d;
            ptr_q <= ptr_d;
            data_q <= data_d;
            ready_q <= 1'b1;
            seq_q <= seq_d;
            exp_q <= exp_d;
        end
    end

    assign o_data_ready = ready_q;
    assign o_data = data_q;
    assign o_data_valid = (state_q == SEND);
    assign o_tx_count = tx_q;
    assign o_rx_count = rx_q;
    assign o_err_count = err_q;
    assign o_done = (state_q == DONE);
endmodule

// File: tb/tb_pe_traffic_gen.sv
// tb_pe_traffic_gen: scoreboard bench for pe_traffic_gen, one bench-driven PE plus a cross-connected loopback pair.
module tb_pe_traffic_gen;
    localparam int P = 3;

    logic sclk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic en_lb = 1'b0;
    logic [31:0] rdata = '0;
    logic rvalid = 1'b0;
    logic tready = 1'b0;

    logic d_ready, d_valid, d_done;
    logic [31:0] d_data, d_tx, d_rx;
    logic [15:0] d_err;
    logic a_ready, a_valid, a_done, b_ready, b_valid, b_done;
    logic [31:0] a_data, a_tx, a_rx, b_data, b_tx, b_rx;
    logic [15:0] a_err, b_err;

    int n_run = 0;
    int n_fail = 0;
    logic [31:0] q_d[$];
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    logic [47:0] q_r[$];
    logic [15:0] m_exp [4];
    logic [31:0] m_rx = '0;
    logic [15:0] m_err = '0;

    always #5 sclk = ~sclk;

    pe_traffic_gen #(.ADDRESS(1), .NUM_PE(4), .DATA_W(32), .PKT_LIMIT(6), .INJ_PERIOD(P)) u_d (
        .sclk(sclk), .rst(rst), .i_enable(en), .i_data(rdata), .i_data_valid(rvalid),
        .o_data_ready(d_ready), .o_data(d_data), .o_data_valid(d_valid), .i_data_ready(tready),
        .o_tx_count(d_tx), .o_rx_count(d_rx), .o_err_count(d_err), .o_done(d_done));

    pe_traffic_gen #(.ADDRESS(0), .NUM_PE(2), .DATA_W(32), .PKT_LIMIT(4), .INJ_PERIOD(0)) u_a (
        .sclk(sclk), .rst(rst), .i_enable(en_lb), .i_data(b_data), .i_data_valid(b_valid),
        .o_data_ready(a_ready), .o_data(a_data), .o_data_valid(a_valid), .i_data_ready(1'b1),
        .o_tx_count(a_tx), .o_rx_count(a_rx), .o_err_count(a_err), .o_done(a_done));

    pe_traffic_gen #(.ADDRESS(1), .NUM_PE(2), .DATA_W(32), .PKT_LIMIT(4), .INJ_PERIOD(0)) u_b (
        .sclk(sclk), .rst(rst), .i_enable(en_lb), .i_data(a_data), .i_data_valid(a_valid),
        .o_data_ready(b_ready), .o_data(b_data), .o_data_valid(b_valid), .i_data_ready(1'b1),
        .o_tx_count(b_tx), .o_rx_count(b_rx), .o_err_count(b_err), .o_done(b_done));

    function automatic logic [31:0] fl(input int dst, input int src, input int seq, input int aw);
        return (32'(seq) << 16) | (32'(src) << aw) | 32'(dst);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!d_valid && n < 40) begin
            @(negedge sclk);
            n++;
        end
        if (!d_valid) check("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic serve(input int hold, input string tag);
        int n;
        logic stable;
        logic [31:0] d0, t0, e;
        wait_valid(n);
        d0 = d_data;
        t0 = d_tx;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge sclk);
            stable = stable && d_valid && (d_data == d0) && (d_tx == t0);
        end
        if (hold > 0) check({tag, "_hold"}, 32'(stable), 32'd1);
        e = (q_d.size() > 0) ? q_d.pop_front() : 32'hDEAD_BEEF;
        check(tag, d_data, e);
        tready = 1'b1;
        @(negedge sclk);
        tready = 1'b0;
        check({tag, "_tx"}, d_tx, t0 + 32'd1);
    endtask

    task automatic send_rx(input int dst, input int src, input int seq, input string tag);
        logic b;
        logic [47:0] e;
        b = (dst != 1);
        if (src < 4 && src != 1) begin
            if (16'(seq) != m_exp[src]) b = 1'b1;
            m_exp[src] = 16'(seq) + 16'd1;
        end else b = 1'b1;
        m_rx = m_rx + 32'd1;
        if (b && m_err != 16'hFFFF) m_err = m_err + 16'd1;
        q_r.push_back({m_rx, m_err});
        rdata = fl(dst, src, seq, 2);
        rvalid = 1'b1;
        @(negedge sclk);
        rvalid = 1'b0;
        e = q_r.pop_front();
        check({tag, "_rx"}, d_rx, e[47:16]);
        check({tag, "_err"}, 32'(d_err), 32'(e[15:0]));
    endtask

    initial begin
        int n, cnt;
        logic [31:0] e;
        for (int i = 0; i < 4; i++) m_exp[i] = '0;
        repeat (3) @(negedge sclk);
        check("rst_valid", 32'(d_valid), 32'd0);
        check("rst_data", d_data, 32'd0);
        check("rst_ready", 32'(d_ready), 32'd0);
        check("rst_tx", d_tx, 32'd0);
        check("rst_rx", d_rx, 32'd0);
        check("rst_err", 32'(d_err), 32'd0);
        check("rst_done", 32'(d_done), 32'd0);
        rst = 1'b0;
        @(negedge sclk);
        check("sink_ready", 32'(d_ready), 32'd1);

        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge sclk);
            if (d_valid) cnt++;
        end
        check("gate_valid", 32'(cnt), 32'd0);

        en = 1'b1;
        q_d.push_back(fl(2, 1, 0, 2));
        q_d.push_back(fl(3, 1, 0, 2));
        wait_valid(n);
        check("first_valid_lat", 32'(n), 32'(P + 1));
        serve(5, "bp");
        @(negedge sclk);
        check("bp_tx_once", d_tx, 32'd1);
        serve(0, "pre1");

        wait_valid(n);
        check("pre_rst_tx", d_tx, 32'd2);
        rst = 1'b1;
        @(negedge sclk);
        rst = 1'b0;
        check("midrst_valid", 32'(d_valid), 32'd0);
        check("midrst_tx", d_tx, 32'd0);
        check("midrst_data", d_data, 32'd0);
        q_d.delete();
        q_d.push_back(fl(2, 1, 0, 2));
        q_d.push_back(fl(3, 1, 0, 2));
        q_d.push_back(fl(0, 1, 0, 2));
        q_d.push_back(fl(2, 1, 1, 2));
        q_d.push_back(fl(3, 1, 1, 2));
        q_d.push_back(fl(0, 1, 1, 2));
        for (int i = 0; i < 6; i++) begin
            serve(0, $sformatf("rr%0d", i));
            if (i == 4) check("done_early", 32'(d_done), 32'd0);
        end
        check("rr_done", 32'(d_done), 32'd1);
        check("rr_tx", d_tx, 32'd6);
        repeat (P + 3) @(negedge sclk);
        check("done_no_valid", 32'(d_valid), 32'd0);

        send_rx(1, 2, 0, "ck_ok");
        send_rx(1, 2, 5, "ck_seq");
        send_rx(3, 2, 6, "ck_dst");
        send_rx(1, 2, 7, "ck_resync");
        send_rx(0, 3, 9, "ck_both");
        send_rx(1, 1, 0, "ck_self");
        send_rx(1, 0, 0, "ck_src0");
        send_rx(1, 0, 0, "ck_dup");

        for (int i = 0; i < 4; i++) begin
            q_a.push_back(fl(1, 0, i, 1));
            q_b.push_back(fl(0, 1, i, 1));
        end
        en_lb = 1'b1;
        for (int c = 0; c < 200 && !(a_done && b_done); c++) begin
            @(negedge sclk);
            if (a_valid) begin
                e = (q_a.size() > 0) ? q_a.pop_front() : 32'hDEAD_BEEF;
                check("lb_a_flit", a_data, e);
            end
            if (b_valid) begin
                e = (q_b.size() > 0) ? q_b.pop_front() : 32'hDEAD_BEEF;
                check("lb_b_flit", b_data, e);
            end
        end
        check("lb_done", {30'd0, a_done, b_done}, 32'd3);
        check("lb_a_tx", a_tx, 32'd4);
        check("lb_a_rx", a_rx, 32'd4);
        check("lb_a_err", 32'(a_err), 32'd0);
        check("lb_b_tx", b_tx, 32'd4);
        check("lb_b_rx", b_rx, 32'd4);
        check("lb_b_err", 32'(b_err), 32'd0);
        check("lb_left", 32'(q_a.size() + q_b.size()), 32'd0);
        check("lb_ready", {30'd0, a_ready, b_ready}, 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
